// File: rtl/parity_ram_pkg.sv
// Shared constants and word type for the parity-protected single-port RAM.
package parity_ram_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  // Stored word layout: {parity, data}
  typedef logic [DATA_W_DEF:0] word_t;

endpackage

// File: rtl/parity_ram_mem.sv
// Storage array: synchronous write port and registered read-before-write read port.
module parity_ram_mem #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WIDTH  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // No reset here so the array and its output register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/parity_ram.sv
// Parity-generating RAM wrapper: computes even parity on write, masks read data during/after reset.
module parity_ram
  import parity_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W:0]   data_out
);

  logic            wr_en;
  logic            rd_en;
  logic            out_valid;
  logic [DATA_W:0] wr_word;
  logic [DATA_W:0] rd_word;

  always_comb begin
    wr_en   = write & ~rst;
    rd_en   = read & ~rst;
    wr_word = {^data_in, data_in};
  end

  parity_ram_mem #(
    .ADDR_W (ADDR_W),
    .WIDTH  (DATA_W + 1)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (address),
    .wdata (wr_word),
    .rdata (rd_word)
  );

  // The RAM output register has no reset; this flag zeroes data_out
  // asynchronously until the first read after reset reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        out_valid <= 1'b0;
    else if (read)  out_valid <= 1'b1;
  end

  always_comb begin
    data_out = '0;
    if (out_valid && !rst) data_out = rd_word;
  end

endmodule

// File: tb/tb_parity_ram.sv
// Scoreboard bench for parity_ram: reads push expected words, the monitor pops and compares.
module tb_parity_ram;
  import parity_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [8:0]  data_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  word_t exp_q[$];
  word_t mem_model [logic [15:0]];
  logic [15:0] wr_addr [100];

  parity_ram #(
    .ADDR_W (16),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .read     (read),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t par_word(input logic [7:0] d);
    return {^d, d};
  endfunction

  // Drive one cycle of stimulus at a negedge; the following posedge consumes it.
  task automatic cyc(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
    write   = w;
    read    = r;
    address = a;
    data_in = d;
    if (r) exp_q.push_back(mem_model.exists(a) ? mem_model[a] : '0);
    if (w) mem_model[a] = par_word(d);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic fire;
    fire = read && !rst;
    #1;
    if (fire) begin
      check("sb_level", exp_q.size(), 1);
      if (exp_q.size() > 0) check("rd_data", data_out, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
    #1;
    check("reset_out", data_out, 9'h000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_hold", data_out, 9'h000);

    // Basic write/read
    cyc(1, 0, 16'h1234, 8'hA5);
    cyc(0, 1, 16'h1234, 8'h00);
    cyc(0, 0, 16'h0000, 8'h00);

    // Address extremes
    cyc(1, 0, 16'hFFFF, 8'h07);
    cyc(1, 0, 16'h0000, 8'h01);
    cyc(0, 1, 16'hFFFF, 8'h00);
    cyc(0, 1, 16'h0000, 8'h00);

    // Read-before-write on the same address, then read the new word
    cyc(1, 0, 16'h0042, 8'h3C);
    cyc(1, 1, 16'h0042, 8'hFF);
    cyc(0, 1, 16'h0042, 8'h00);

    // Hold with read low while address moves
    cyc(1, 0, 16'h0100, 8'hAB);
    cyc(0, 1, 16'h0100, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0100 + 16'(i * 7), 8'h00);
      check("hold", data_out, 9'h1AB);
    end

    // Random writes (half into a small window to force overwrites), reverse readback
    for (int i = 0; i < 100; i++) begin
      wr_addr[i] = (i % 2 == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 65535));
      cyc(1, 0, wr_addr[i], 8'($urandom_range(0, 255)));
    end
    for (int i = 99; i >= 0; i--) cyc(0, 1, wr_addr[i], 8'h00);
    cyc(0, 0, 16'h0000, 8'h00);

    // Asynchronous reset mid-cycle; memory must survive, ops ignored while held
    cyc(1, 0, 16'h0010, 8'h55);
    cyc(0, 1, 16'h0010, 8'h00);
    cyc(0, 0, 16'h0000, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", data_out, 9'h000);
    write = 1'b1; read = 1'b1; address = 16'h0010; data_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_held", data_out, 9'h000);
    write = 1'b0; read = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release", data_out, 9'h000);
    cyc(0, 1, 16'h0010, 8'h00);
    cyc(0, 0, 16'h0000, 8'h00);

    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
